// File: rtl/instr_loader.sv
// instr_loader: writes a packed program into instruction memory,
// then launches the processor via working and optionally auto-halts.
//
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   in_valid/in_ready  : instruction field stream handshake
//   in_icode..in_valC  : decoded fields, in_last marks end of program
//   stop, reload       : halt request in RUN, back to LOAD from HALT
//   addr/wEn/wDat      : instruction-memory write port
//   working            : processor run enable
//   n_loaded           : words written for current program
//   overflow           : sticky, DEPTH reached without in_last
//   bad_icode          : sticky, accepted icode above 4'hB
module instr_loader #(
  parameter int ADDR_W     = 9,
  parameter int DEPTH      = 512,
  parameter int RUN_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [15:0]       in_valC,
  input  logic              in_last,
  input  logic              stop,
  input  logic              reload,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [31:0]       wDat,
  output logic              working,
  output logic [ADDR_W:0]   n_loaded,
  output logic              overflow,
  output logic              bad_icode
);

  typedef enum logic [1:0] {
    LOAD,
    GAP,
    RUN,
    HALT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR =
    ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL =
    (ADDR_W + 1)'(DEPTH);
  localparam logic [31:0] RUN_LAST =
    32'(RUN_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       run_cnt;
  logic              fire;
  logic              expire;
  logic [31:0]       word;

  assign in_ready = (state == LOAD);
  assign fire     = in_valid & in_ready;

  assign word = {in_icode, in_ifun,
                 in_rA, in_rB, in_valC};

  // Budget only applies when a nonzero run length is configured.
  assign expire = (RUN_CYCLES != 0) &&
                  (run_cnt == RUN_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      addr      <= '0;
      wEn       <= 1'b0;
      wDat      <= '0;
      working   <= 1'b0;
      n_loaded  <= '0;
      overflow  <= 1'b0;
      bad_icode <= 1'b0;
      run_cnt   <= '0;
    end else begin
      wEn     <= 1'b0;
      working <= 1'b0;
      unique case (state)
        LOAD: begin
          if (fire) begin
            wEn    <= 1'b1;
            addr   <= wr_ptr;
            wDat   <= word;
            wr_ptr <= wr_ptr + 1'b1;
            if (n_loaded != FULL)
              n_loaded <= n_loaded + 1'b1;
            if (in_icode > 4'hB)
              bad_icode <= 1'b1;
            if (in_last) begin
              state <= GAP;
            end else if (wr_ptr == LAST_PTR) begin
              overflow <= 1'b1;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          addr  <= '0;
          state <= RUN;
        end
        RUN: begin
          addr    <= '0;
          run_cnt <= run_cnt + 32'd1;
          // A stop drops working on the very next cycle;
          // budget expiry keeps it for the final cycle.
          working <= ~stop;
          if (stop || expire)
            state <= HALT;
        end
        HALT: begin
          if (reload) begin
            state    <= LOAD;
            wr_ptr   <= '0;
            n_loaded <= '0;
            run_cnt  <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader
// (DEPTH=4, RUN_CYCLES=5).
module tb_instr_loader;

  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_icode = '0;
  logic [3:0]    in_ifun = '0;
  logic [3:0]    in_rA = '0;
  logic [3:0]    in_rB = '0;
  logic [15:0]   in_valC = '0;
  logic          in_last = 1'b0;
  logic          stop = 1'b0;
  logic          reload = 1'b0;
  logic [AW-1:0] addr;
  logic          wEn;
  logic [31:0]   wDat;
  logic          working;
  logic [AW:0]   n_loaded;
  logic          overflow;
  logic          bad_icode;

  instr_loader #(
    .ADDR_W(AW),
    .DEPTH(4),
    .RUN_CYCLES(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_icode(in_icode),
    .in_ifun(in_ifun),
    .in_rA(in_rA),
    .in_rB(in_rB),
    .in_valC(in_valC),
    .in_last(in_last),
    .stop(stop),
    .reload(reload),
    .addr(addr),
    .wEn(wEn),
    .wDat(wDat),
    .working(working),
    .n_loaded(n_loaded),
    .overflow(overflow),
    .bad_icode(bad_icode)
  );

  always #10 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int            checks = 0;
  int            errors = 0;
  wr_t           wq[$];
  int            rq[$];
  logic [AW-1:0] exp_ptr = '0;
  wr_t           mon_e;
  int            run_len = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h",
               name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and run lengths.
  always @(negedge clock) begin
    if (wEn === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got %h:%h want none",
                 addr, wDat);
      end else begin
        mon_e = wq.pop_front();
        chk("write_addr", 32'(addr), 32'(mon_e.a));
        chk("write_data", wDat, mon_e.d);
      end
    end
    if (working === 1'b1) begin
      run_len++;
    end else if (run_len != 0) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_run got %0d want none",
                 run_len);
      end else begin
        chk("run_len", 32'(run_len), 32'(rq.pop_front()));
      end
      run_len = 0;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] ic,
                      input logic [3:0] fn,
                      input logic [3:0] ra,
                      input logic [3:0] rb,
                      input logic [15:0] vc,
                      input logic last);
    in_icode = ic;
    in_ifun  = fn;
    in_rA    = ra;
    in_rB    = rb;
    in_valC  = vc;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++)
      tick();
    chk("send_ready", 32'(in_ready), 32'd1);
    wq.push_back({exp_ptr, ic, fn, ra, rb, vc});
    exp_ptr = exp_ptr + 1'b1;
    tick();
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_run;
    for (int i = 0; i < 10 && !working; i++)
      tick();
    chk("run_start", 32'(working), 32'd1);
  endtask

  task automatic wait_halt;
    for (int i = 0; i < 40 && working; i++)
      tick();
    chk("halt_timeout", 32'(working), 32'd0);
  endtask

  task automatic do_reload;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    exp_ptr = '0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wen", 32'(wEn), 32'd0);
    chk("rst_working", 32'(working), 32'd0);
    chk("rst_nload", 32'(n_loaded), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_bad", 32'(bad_icode), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdat", wDat, 32'd0);
    reset = 1'b0;

    // Three back-to-back instructions, auto-halt after 5.
    rq.push_back(5);
    send(4'h1, 4'h0, 4'hF, 4'h5, 16'h0008, 1'b0);
    send(4'h2, 4'h1, 4'h4, 4'h5, 16'h0000, 1'b0);
    send(4'h2, 4'h0, 4'h1, 4'h2, 16'h0000, 1'b1);
    idle();
    chk("gap_ready", 32'(in_ready), 32'd0);
    tick();
    chk("gap_wen", 32'(wEn), 32'd0);
    chk("gap_working", 32'(working), 32'd0);
    tick();
    chk("run_working", 32'(working), 32'd1);
    chk("run_addr", 32'(addr), 32'd0);
    chk("run_nload", 32'(n_loaded), 32'd3);
    wait_halt();
    chk("halt_ready", 32'(in_ready), 32'd0);
    tick();
    chk("halt_working", 32'(working), 32'd0);
    do_reload();
    chk("reload_ready", 32'(in_ready), 32'd1);
    chk("reload_nload", 32'(n_loaded), 32'd0);

    // Bubbled input, in_last ignored while not valid.
    rq.push_back(5);
    send(4'h3, 4'h0, 4'hF, 4'h2, 16'h0010, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b1;
    tick();
    chk("bubble_wen1", 32'(wEn), 32'd0);
    chk("bubble_rdy1", 32'(in_ready), 32'd1);
    tick();
    chk("bubble_wen2", 32'(wEn), 32'd0);
    chk("bubble_rdy2", 32'(in_ready), 32'd1);
    send(4'h6, 4'h1, 4'h2, 4'h3, 16'h0000, 1'b1);
    idle();
    wait_run();
    chk("bubble_nload", 32'(n_loaded), 32'd2);
    wait_halt();
    do_reload();

    // Overflow at DEPTH=4 with no last marker.
    rq.push_back(5);
    send(4'h1, 4'h0, 4'hF, 4'h1, 16'h0001, 1'b0);
    send(4'h1, 4'h0, 4'hF, 4'h2, 16'h0002, 1'b0);
    send(4'h1, 4'h0, 4'hF, 4'h3, 16'h0003, 1'b0);
    send(4'h1, 4'h0, 4'hF, 4'h4, 16'h0004, 1'b0);
    idle();
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_nload", 32'(n_loaded), 32'd4);
    wait_run();
    chk("ovf_run_ready", 32'(in_ready), 32'd0);
    wait_halt();
    do_reload();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Bad icode, then stop on the 2nd RUN cycle.
    rq.push_back(1);
    send(4'hD, 4'h0, 4'h0, 4'h0, 16'h0000, 1'b1);
    idle();
    chk("bad_flag", 32'(bad_icode), 32'd1);
    wait_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_working", 32'(working), 32'd0);
    chk("stop_ready", 32'(in_ready), 32'd0);
    tick();
    chk("stop_hold", 32'(working), 32'd0);
    do_reload();

    // Reset in the middle of RUN.
    rq.push_back(1);
    send(4'h4, 4'h0, 4'h1, 4'hF, 16'h0020, 1'b1);
    idle();
    wait_run();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_ptr = '0;
    chk("rr_working", 32'(working), 32'd0);
    chk("rr_ready", 32'(in_ready), 32'd1);
    chk("rr_nload", 32'(n_loaded), 32'd0);
    chk("rr_ovf", 32'(overflow), 32'd0);
    chk("rr_bad", 32'(bad_icode), 32'd0);
    chk("rr_wen", 32'(wEn), 32'd0);

    for (int i = 0; i < 10; i++)
      tick();
    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
